// File: rtl/fir_pkg.sv
// Shared definitions for the FIR sequencing controller: state encoding,
// default tap count and the address-width helper.
package fir_pkg;

  localparam int unsigned NUM_COEF = 17;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // Ceiling log2; a single-entry range still gets a 1-bit address.
  function automatic int unsigned fir_log2(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/modn_ptr.sv
// Mod-N incrementing counter with synchronous clear and count enable.
module modn_ptr #(
  parameter int unsigned N = 17,
  parameter int unsigned W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == W'(N - 1)) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/fir_seq_ctrl.sv
// Sequencer for a single-MAC FIR: accepts one sample, walks all taps through
// the external ROM/sample buffer, then pulses out_valid.
module fir_seq_ctrl
  import fir_pkg::*;
#(
  parameter int unsigned Num_coef = NUM_COEF,
  parameter int unsigned AW       = fir_log2(Num_coef)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sample_valid,
  input  logic          ovr_clr,
  output logic          ready,
  output logic          smp_wr_en,
  output logic [AW-1:0] smp_wr_addr,
  output logic [AW-1:0] smp_rd_addr,
  output logic [AW-1:0] coef_addr,
  output logic          mac_clr,
  output logic          mac_en,
  output logic          out_valid,
  output logic          overrun
);

  state_e        state_q, state_d;
  logic [AW-1:0] newest_q, newest_d;
  logic [AW-1:0] wr_ptr, k;
  logic          accept, drop, in_run, k_last;
  logic          mac_en_q, mac_clr_q, out_valid_q, overrun_q;
  logic [AW:0]   rd_wrapped;

  // ready is gated by rst_n so every 1-bit output reads 0 while in reset.
  assign ready     = (state_q == S_IDLE) && rst_n;
  assign accept    = sample_valid && ready;
  assign drop      = sample_valid && !ready && rst_n;
  assign in_run    = (state_q == S_RUN);
  assign k_last    = (k == AW'(Num_coef - 1));
  assign smp_wr_en = accept;
  assign smp_wr_addr = wr_ptr;

  modn_ptr #(.N(Num_coef), .W(AW)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (1'b0),
    .en_i  (accept),
    .cnt_o (wr_ptr)
  );

  modn_ptr #(.N(Num_coef), .W(AW)) u_tap (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (accept),
    .en_i  (in_run),
    .cnt_o (k)
  );

  // (newest - k) mod N without relying on power-of-two wrap.
  assign rd_wrapped = {1'b0, newest_q} + (AW+1)'(Num_coef) - {1'b0, k};

  always_comb begin
    coef_addr   = '0;
    smp_rd_addr = '0;
    if (in_run) begin
      coef_addr   = k;
      smp_rd_addr = (newest_q >= k) ? (newest_q - k) : rd_wrapped[AW-1:0];
    end
  end

  always_comb begin
    state_d  = state_q;
    newest_d = newest_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d  = S_RUN;
          newest_d = wr_ptr;
        end
      end
      S_RUN:   if (k_last) state_d = S_FLUSH;
      S_FLUSH: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      newest_q    <= '0;
      mac_en_q    <= 1'b0;
      mac_clr_q   <= 1'b0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      newest_q    <= newest_d;
      mac_en_q    <= in_run;
      mac_clr_q   <= in_run && (k == '0);
      out_valid_q <= (state_q == S_FLUSH);
      overrun_q   <= drop || (overrun_q && !ovr_clr);
    end
  end

  assign mac_en    = mac_en_q;
  assign mac_clr   = mac_clr_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Self-checking bench for fir_seq_ctrl with external ROM/buffer/MAC models.
module tb_fir_seq_ctrl;

  localparam int unsigned N  = 17;
  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sample_valid = 1'b0;
  logic          ovr_clr = 1'b0;
  logic          ready, smp_wr_en, mac_clr, mac_en, out_valid, overrun;
  logic [AW-1:0] smp_wr_addr, smp_rd_addr, coef_addr;

  always #5 clk = ~clk;

  fir_seq_ctrl #(.Num_coef(N), .AW(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_valid (sample_valid),
    .ovr_clr      (ovr_clr),
    .ready        (ready),
    .smp_wr_en    (smp_wr_en),
    .smp_wr_addr  (smp_wr_addr),
    .smp_rd_addr  (smp_rd_addr),
    .coef_addr    (coef_addr),
    .mac_clr      (mac_clr),
    .mac_en       (mac_en),
    .out_valid    (out_valid),
    .overrun      (overrun)
  );

  // External ROM, sample buffer and MAC, each with a one-cycle read.
  logic [7:0]  rom [N];
  logic [7:0]  mem [N];
  logic [7:0]  rom_q, buf_q, sample_data;
  logic [31:0] acc;
  logic        mem_clr;

  always @(posedge clk) begin
    rom_q <= rom[coef_addr];
    buf_q <= mem[smp_rd_addr];
    if (mem_clr) begin
      for (int i = 0; i < N; i++) mem[i] <= 8'd0;
    end else if (smp_wr_en) begin
      mem[smp_wr_addr] <= sample_data;
    end
    if (mac_en) acc <= mac_clr ? 32'(rom_q) * 32'(buf_q) : acc + 32'(rom_q) * 32'(buf_q);
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (model cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference model: timing is expressed as offset from the accepting cycle.
  int          cyc = 0;
  int          t_acc = 0;
  bit          have_t = 0;
  int unsigned wrp = 0;
  int unsigned newest = 0;
  bit          ovr = 0;
  int unsigned hist[$];

  function automatic bit m_busy();
    int d;
    d = cyc - t_acc;
    return have_t && d >= 1 && d <= N + 2;
  endfunction

  function automatic longint ref_y();
    longint s;
    s = 0;
    for (int i = 0; i < N && i < hist.size(); i++) s += longint'(rom[i]) * longint'(hist[i]);
    return s;
  endfunction

  task automatic cycle(input bit sv, input bit clr, input logic [7:0] data);
    bit busy, run;
    int d, k;
    sample_valid = sv;
    ovr_clr      = clr;
    sample_data  = data;
    @(negedge clk);
    busy = m_busy();
    d    = cyc - t_acc;
    run  = busy && d <= N;
    k    = d - 1;
    check("ready",     ready,       !busy);
    check("wr_en",     smp_wr_en,   sv && !busy);
    check("wr_addr",   smp_wr_addr, wrp);
    check("coef_addr", coef_addr,   run ? k : 0);
    check("rd_addr",   smp_rd_addr, run ? (int'(newest) + N - k) % N : 0);
    check("mac_en",    mac_en,      busy && d >= 2 && d <= N + 1);
    check("mac_clr",   mac_clr,     busy && d == 2);
    check("out_valid", out_valid,   busy && d == N + 2);
    check("overrun",   overrun,     ovr);
    if (busy && d == N + 2) check("fir_out", acc, ref_y());
    if (sv && !busy) begin
      t_acc  = cyc;
      have_t = 1;
      newest = wrp;
      wrp    = (wrp + 1) % N;
      hist.push_front(int'(data));
      if (hist.size() > N) void'(hist.pop_back());
    end
    ovr = (sv && busy) || (ovr && !clr);
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs();
    check("rst_ready",   ready,       0);
    check("rst_wr_en",   smp_wr_en,   0);
    check("rst_wr_addr", smp_wr_addr, 0);
    check("rst_rd_addr", smp_rd_addr, 0);
    check("rst_coef",    coef_addr,   0);
    check("rst_mac_clr", mac_clr,     0);
    check("rst_mac_en",  mac_en,      0);
    check("rst_out_vld", out_valid,   0);
    check("rst_overrun", overrun,     0);
  endtask

  task automatic do_reset();
    sample_valid = 1'b0;
    ovr_clr      = 1'b0;
    #2;
    rst_n   = 1'b0;
    mem_clr = 1'b1;
    #1;
    check_reset_outputs();
    have_t = 0;
    wrp    = 0;
    newest = 0;
    ovr    = 0;
    hist.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n   = 1'b1;
    mem_clr = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (m_busy() && guard < 4 * N) begin
      cycle(0, 0, 8'd0);
      guard++;
    end
  endtask

  initial begin
    int sent;
    for (int i = 0; i < N; i++) rom[i] = 8'($urandom_range(1, 255));
    mem_clr = 1'b1;
    sample_data = 8'd0;
    #12;
    check_reset_outputs();
    @(negedge clk);
    rst_n   = 1'b1;
    mem_clr = 1'b0;
    @(posedge clk);
    #1;

    // Impulse, 18 back-to-back samples so the write pointer wraps.
    sent = 0;
    while (sent < N + 1) begin
      if (!m_busy()) begin
        cycle(1, 0, (sent == 0) ? 8'd1 : 8'd0);
        sent++;
      end else begin
        cycle(0, 0, 8'd0);
      end
    end
    wait_idle();

    // Dropped sample, clear, and clear racing a new violation.
    cycle(1, 0, 8'd7);
    repeat (4) cycle(0, 0, 8'd0);
    cycle(1, 0, 8'd9);
    cycle(0, 0, 8'd0);
    cycle(0, 1, 8'd0);
    cycle(0, 0, 8'd0);
    cycle(1, 1, 8'd3);
    cycle(0, 0, 8'd0);
    cycle(0, 1, 8'd0);
    wait_idle();

    repeat (700) cycle($urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0, 8'($urandom));
    wait_idle();

    // Reset in the middle of a computation.
    cycle(1, 0, 8'd5);
    repeat (8) cycle(0, 0, 8'd0);
    do_reset();
    cycle(1, 0, 8'd11);
    wait_idle();
    cycle(0, 0, 8'd0);

    repeat (200) cycle($urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0, 8'($urandom));
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
